// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - RISC-V load/store unit bridging byte requests to a word-addressed data memory
//
// Converts LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses. Sub-word stores use
// read-modify-write; loads are lane-extracted and sign/zero extended.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (reject misaligned H/W accesses).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_funct3  store flag and RISC-V access size/sign code
//   req_addr, req_wdata byte address and store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  extended load data (0 for stores/errors), error flag
//   mem_wr_en           one-cycle write strobe
//   mem_addr            word index (req_addr >> 2), registered
//   mem_wr_data         full word to write, registered
//   mem_rd_data         combinational read data for mem_addr
module lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata_lo;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept = req_valid && req_ready;

  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      w_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // funct3[1:0] encodes size for both signed and unsigned variants.
  always_comb begin
    w_misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal || w_misalign;

  // Lane selection works on the word returned for the latched address.
  always_comb begin
    w_byte = mem_rd_data[7:0];
    case (r_lane)
      2'd0: w_byte = mem_rd_data[7:0];
      2'd1: w_byte = mem_rd_data[15:8];
      2'd2: w_byte = mem_rd_data[23:16];
      2'd3: w_byte = mem_rd_data[31:24];
    endcase
    w_half = r_lane[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    w_load = mem_rd_data;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rd_data;
    endcase

    w_merged = mem_rd_data;
    if (r_funct3 == 3'b000) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata_lo[7:0];
        2'd1: w_merged[15:8]  = r_wdata_lo[7:0];
        2'd2: w_merged[23:16] = r_wdata_lo[7:0];
        2'd3: w_merged[31:24] = r_wdata_lo[7:0];
      endcase
    end else if (r_funct3 == 3'b001) begin
      if (r_lane[1]) w_merged[31:16] = r_wdata_lo;
      else           w_merged[15:0]  = r_wdata_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !reset;
        if (w_accept) begin
          if (w_err)                              w_next = S_RESP;
          else if (req_we && req_funct3 == 3'b010) w_next = S_WR;
          else                                    w_next = S_RD;
        end
      end
      S_RD:   w_next = r_we ? S_WR : S_RESP;
      S_WR: begin
        mem_wr_en = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_lane        <= 2'd0;
      r_wdata_lo    <= 16'd0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_lane      <= req_addr[1:0];
            r_wdata_lo  <= req_wdata[15:0];
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_err;
            // Errored requests never touch memory, so the memory bus holds.
            if (!w_err) begin
              r_mem_addr <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
              if (req_we && req_funct3 == 3'b010) r_mem_wr_data <= req_wdata;
            end
          end
        end
        S_RD: begin
          if (r_we) r_mem_wr_data <= w_merged;
          else      r_rsp_rdata   <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - directed self-checking bench for lsu_mem_if
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  int n_total = 0;
  int n_bad   = 0;

  int          got_lat;
  int          got_nwr;
  int          busy_rdy;
  logic        got_rsp;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] got_waddr;
  logic [31:0] got_wdata;
  logic        ready_after;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr]      <= pre_data;
    else if (mem_wr_en) mem[mem_addr[5:0]] <= mem_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_bound", 32'(guard < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got_lat = 0; got_nwr = 0; busy_rdy = 0; got_rsp = 1'b0;
    got_rdata = 32'hx; got_err = 1'bx; got_waddr = 32'hx; got_wdata = 32'hx;
    while (!got_rsp && got_lat < 10) begin
      @(negedge clk);
      got_lat++;
      if (req_ready) busy_rdy++;
      if (mem_wr_en) begin
        got_nwr++;
        got_waddr = mem_addr;
        got_wdata = mem_wr_data;
      end
      if (rsp_valid) begin
        got_rsp   = 1'b1;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
    end
    chk("rsp_seen", 32'(got_rsp), 32'd1);
    @(negedge clk);
    ready_after = req_ready;
    if (rsp_valid) chk("rsp_single_pulse", 32'd1, 32'd0);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'h0);
    chk({tag, "_rdata"}, got_rdata, exp);
    chk({tag, "_lat"}, 32'(got_lat), 32'd2);
    chk({tag, "_err"}, 32'(got_err), 32'd0);
    chk({tag, "_nwr"}, 32'(got_nwr), 32'd0);
  endtask

  initial begin
    int nwr_rst;
    int nrsp_rst;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b1; pre_addr = 6'd3; pre_data = 32'h87654321;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",  rsp_rdata, 32'd0);
    chk("rst_err",    32'(rsp_err), 32'd0);
    chk("rst_wren",   32'(mem_wr_en), 32'd0);
    chk("rst_maddr",  mem_addr, 32'd0);
    chk("rst_mwdata", mem_wr_data, 32'd0);
    reset = 1'b0; pre_we = 1'b0;
    #1;
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    ld("lb_0f",  3'b000, 32'h0F, 32'hFFFFFF87);
    ld("lhu_0e", 3'b101, 32'h0E, 32'h00008765);
    ld("lh_0c",  3'b001, 32'h0C, 32'h00004321);
    ld("lbu_0d", 3'b100, 32'h0D, 32'h00000043);

    do_req(1'b1, 3'b000, 32'h0D, 32'h123456AA);
    chk("sb_nwr",   32'(got_nwr), 32'd1);
    chk("sb_waddr", got_waddr, 32'd3);
    chk("sb_wdata", got_wdata, 32'h8765AA21);
    chk("sb_lat",   32'(got_lat), 32'd3);
    chk("sb_rdata", got_rdata, 32'd0);
    chk("sb_busy_ready", 32'(busy_rdy), 32'd0);
    ld("lw_0c", 3'b010, 32'h0C, 32'h8765AA21);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_nwr",   32'(got_nwr), 32'd1);
    chk("sw_waddr", got_waddr, 32'd4);
    chk("sw_wdata", got_wdata, 32'hDEADBEEF);
    chk("sw_lat",   32'(got_lat), 32'd2);
    chk("sw_busy_ready", 32'(busy_rdy), 32'd0);
    chk("sw_ready_after", 32'(ready_after), 32'd1);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);

    do_req(1'b0, 3'b011, 32'h0C, 32'h0);
    chk("ill_ld_lat",   32'(got_lat), 32'd1);
    chk("ill_ld_err",   32'(got_err), 32'd1);
    chk("ill_ld_rdata", got_rdata, 32'd0);
    chk("ill_ld_nwr",   32'(got_nwr), 32'd0);

    do_req(1'b1, 3'b100, 32'h0C, 32'hFFFFFFFF);
    chk("ill_st_lat", 32'(got_lat), 32'd1);
    chk("ill_st_err", 32'(got_err), 32'd1);
    chk("ill_st_nwr", 32'(got_nwr), 32'd0);
    chk("ill_st_mem3", mem[3], 32'h8765AA21);

    do_req(1'b1, 3'b010, 32'h11, 32'h11112222);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("sw_mis_err",  32'(got_err), 32'd1);
    chk("sw_mis_lat",  32'(got_lat), 32'd1);
    chk("sw_mis_nwr",  32'(got_nwr), 32'd0);
    chk("sw_mis_mem4", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 3'b001, 32'h0D, 32'h0);
    chk("lh_mis_err",   32'(got_err), 32'd1);
    chk("lh_mis_rdata", got_rdata, 32'd0);
    chk("lh_mis_lat",   32'(got_lat), 32'd1);
`else
    chk("sw_mis_err",  32'(got_err), 32'd0);
    chk("sw_mis_lat",  32'(got_lat), 32'd2);
    chk("sw_mis_nwr",  32'(got_nwr), 32'd1);
    chk("sw_mis_mem4", mem[4], 32'h11112222);
    ld("lh_0d", 3'b001, 32'h0D, 32'hFFFFAA21);
`endif

    // SH with reset asserted while the read cycle is in progress.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0E; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rd_maddr", mem_addr, 32'd3);
    reset = 1'b1;
    #1;
    chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_maddr_rst", mem_addr, 32'd0);
    nwr_rst = 0; nrsp_rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_wr_en) nwr_rst++;
      if (rsp_valid) nrsp_rst++;
    end
    chk("abort_nwr",  32'(nwr_rst), 32'd0);
    chk("abort_nrsp", 32'(nrsp_rst), 32'd0);
    chk("abort_mem3", mem[3], 32'h8765AA21);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
